m_memarb: RTL and testbench

M_MEMARB -- requirements
Module: m_memarb

---
 rtl/m_memarb.sv | 120 ++++++++++++
 tb/tb_m_memarb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// Arbiter that shares one single-port memory between a fetch port and a data port.
// Define MEMARB_STATS_EN to add the r_iwait/r_dwait wait-cycle counters.
module m_memarb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ireq,
  input  logic [11:0] w_iaddr,
  output logic        r_iack,
  output logic [31:0] r_idata,
  input  logic        w_dreq,
  input  logic        w_dwe,
  input  logic [11:0] w_daddr,
  input  logic [31:0] w_ddin,
  output logic        r_dack,
  output logic [31:0] r_ddata,
  output logic [11:0] r_maddr,
  output logic        r_mwe,
  output logic [31:0] r_mdin,
  input  logic [31:0] w_mdout,
  output logic        r_busy
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0] r_iwait,
  output logic [31:0] r_dwait
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] r_starve;
  logic       sel_data;
  logic       ielig;
  logic       delig;
  logic       at_limit;
  logic       grant_d;
  logic       grant_i;

  // A requester whose ack is high this cycle is finishing, not asking again.
  assign ielig    = w_ireq & ~r_iack;
  assign delig    = w_dreq & ~r_dack;
  assign at_limit = (r_starve == 4'(STARVE_LIMIT));
  assign grant_d  = (state == IDLE) & delig & (~ielig | ~at_limit);
  assign grant_i  = (state == IDLE) & ielig & ~grant_d;
  assign r_busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= IDLE;
      r_iack   <= 1'b0;
      r_dack   <= 1'b0;
      r_mwe    <= 1'b0;
      r_starve <= 4'd0;
      r_idata  <= 32'd0;
      r_ddata  <= 32'd0;
      r_maddr  <= 12'd0;
      r_mdin   <= 32'd0;
      sel_data <= 1'b0;
    end else begin
      state  <= state_next;
      r_iack <= 1'b0;
      r_dack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            r_maddr  <= w_daddr;
            r_mwe    <= w_dwe;
            r_mdin   <= w_ddin;
            sel_data <= 1'b1;
            if (ielig) r_starve <= r_starve + 4'd1;
          end else if (grant_i) begin
            r_maddr  <= w_iaddr;
            r_mwe    <= 1'b0;
            r_mdin   <= w_ddin;
            sel_data <= 1'b0;
            r_starve <= 4'd0;
          end
        end
        ACCESS: r_mwe <= 1'b0;
        // Memory read data arrives one cycle after the address, i.e. during RESP.
        RESP: begin
          if (sel_data) begin
            r_ddata <= w_mdout;
            r_dack  <= 1'b1;
          end else begin
            r_idata <= w_mdout;
            r_iack  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_iwait <= 32'd0;
      r_dwait <= 32'd0;
    end else begin
      if (ielig && (r_iwait != 32'hFFFF_FFFF)) r_iwait <= r_iwait + 32'd1;
      if (delig && (r_dwait != 32'hFFFF_FFFF)) r_dwait <= r_dwait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_memarb.sv
// Directed self-checking bench for m_memarb with a read-first behavioural memory.
module tb_m_memarb;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_ireq = 1'b0;
  logic [11:0] w_iaddr = 12'd0;
  logic        r_iack;
  logic [31:0] r_idata;
  logic        w_dreq = 1'b0;
  logic        w_dwe = 1'b0;
  logic [11:0] w_daddr = 12'd0;
  logic [31:0] w_ddin = 32'd0;
  logic        r_dack;
  logic [31:0] r_ddata;
  logic [11:0] r_maddr;
  logic        r_mwe;
  logic [31:0] r_mdin;
  logic [31:0] w_mdout;
  logic        r_busy;
`ifdef MEMARB_STATS_EN
  logic [31:0] r_iwait;
  logic [31:0] r_dwait;
`endif

  int total = 0;
  int bad = 0;
  int mwe_pulses = 0;

  logic [31:0] mem [0:4095];
  logic        loaded = 1'b0;

  m_memarb #(.STARVE_LIMIT(4)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_ireq  (w_ireq),
    .w_iaddr (w_iaddr),
    .r_iack  (r_iack),
    .r_idata (r_idata),
    .w_dreq  (w_dreq),
    .w_dwe   (w_dwe),
    .w_daddr (w_daddr),
    .w_ddin  (w_ddin),
    .r_dack  (r_dack),
    .r_ddata (r_ddata),
    .r_maddr (r_maddr),
    .r_mwe   (r_mwe),
    .r_mdin  (r_mdin),
    .w_mdout (w_mdout),
    .r_busy  (r_busy)
`ifdef MEMARB_STATS_EN
    ,
    .r_iwait (r_iwait),
    .r_dwait (r_dwait)
`endif
  );

  always #5 w_clk = ~w_clk;

  // Single-port memory: registered read returns the pre-write word.
  always @(posedge w_clk) begin
    if (!loaded) begin
      mem[12'h005] <= 32'h2014_000B;
      mem[12'h009] <= 32'h1111_1111;
      mem[12'h100] <= 32'hF00D_0100;
      mem[12'h200] <= 32'hDA7A_0200;
      mem[12'h030] <= 32'hDEAD_BEEF;
      mem[12'h031] <= 32'h3131_3131;
      mem[12'h040] <= 32'h4040_4040;
      mem[12'h041] <= 32'h4141_4141;
      mem[12'h042] <= 32'h4242_4242;
      mem[12'h050] <= 32'h0000_0005;
      loaded <= 1'b1;
    end else if (r_mwe) begin
      mem[r_maddr] <= r_mdin;
    end
    w_mdout <= mem[r_maddr];
  end

  always @(posedge w_clk) if (r_mwe === 1'b1) mwe_pulses++;

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    w_ireq = 1'b0;
    w_dreq = 1'b0;
    w_dwe = 1'b0;
    tick();
    w_rst = 1'b0;
  endtask

  task automatic test_reset();
    w_ireq = 1'b1;
    w_dreq = 1'b1;
    w_dwe = 1'b1;
    w_ddin = 32'hFFFF_FFFF;
    tick();
    tick();
    total++; if (r_iack !== 1'b0) begin bad++; $display("FAIL reset_iack got=%b want=0", r_iack); end
    total++; if (r_dack !== 1'b0) begin bad++; $display("FAIL reset_dack got=%b want=0", r_dack); end
    total++; if (r_mwe !== 1'b0) begin bad++; $display("FAIL reset_mwe got=%b want=0", r_mwe); end
    total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", r_busy); end
    total++; if (r_idata !== 32'd0) begin bad++; $display("FAIL reset_idata got=%h want=0", r_idata); end
    total++; if (r_ddata !== 32'd0) begin bad++; $display("FAIL reset_ddata got=%h want=0", r_ddata); end
    total++; if (r_maddr !== 12'd0) begin bad++; $display("FAIL reset_maddr got=%h want=0", r_maddr); end
    total++; if (r_mdin !== 32'd0) begin bad++; $display("FAIL reset_mdin got=%h want=0", r_mdin); end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    w_ireq = 1'b1;
    w_iaddr = 12'h005;
    tick();
    total++; if (r_maddr !== 12'h005) begin bad++; $display("FAIL fetch_maddr got=%h want=005", r_maddr); end
    total++; if (r_busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%b want=1", r_busy); end
    tick();
    total++; if (r_iack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%b want=0", r_iack); end
    tick();
    total++; if (r_iack !== 1'b1) begin bad++; $display("FAIL fetch_ack got=%b want=1", r_iack); end
    total++; if (r_idata !== 32'h2014_000B) begin bad++; $display("FAIL fetch_idata got=%h want=2014000b", r_idata); end
    w_ireq = 1'b0;
    tick();
    total++; if (r_iack !== 1'b0) begin bad++; $display("FAIL fetch_ack_pulse got=%b want=0", r_iack); end
    total++; if (r_idata !== 32'h2014_000B) begin bad++; $display("FAIL fetch_idata_hold got=%h want=2014000b", r_idata); end
  endtask

  task automatic test_write_read();
    int base;
    do_reset();
    base = mwe_pulses;
    w_dreq = 1'b1;
    w_dwe = 1'b1;
    w_daddr = 12'h009;
    w_ddin = 32'h0000_00AB;
    tick();
    total++; if (r_mwe !== 1'b1 || r_maddr !== 12'h009) begin bad++; $display("FAIL write_mwe got=%b/%h want=1/009", r_mwe, r_maddr); end
    total++; if (r_mdin !== 32'h0000_00AB) begin bad++; $display("FAIL write_mdin got=%h want=000000ab", r_mdin); end
    tick();
    total++; if (r_mwe !== 1'b0) begin bad++; $display("FAIL write_mwe_clear got=%b want=0", r_mwe); end
    tick();
    total++; if (r_dack !== 1'b1 || r_ddata !== 32'h1111_1111) begin bad++; $display("FAIL write_prewrite got=%b/%h want=1/11111111", r_dack, r_ddata); end
    w_dreq = 1'b0;
    w_dwe = 1'b0;
    tick();
    total++; if (mwe_pulses - base !== 1) begin bad++; $display("FAIL write_pulse_count got=%0d want=1", mwe_pulses - base); end
    w_dreq = 1'b1;
    tick();
    tick();
    tick();
    total++; if (r_dack !== 1'b1 || r_ddata !== 32'h0000_00AB) begin bad++; $display("FAIL readback got=%b/%h want=1/000000ab", r_dack, r_ddata); end
    w_dreq = 1'b0;
    tick();
  endtask

  // The fetch requester withdraws during each access so both contend at every decision.
  task automatic test_starvation();
    logic [11:0] exp_addr;
    do_reset();
    w_iaddr = 12'h100;
    w_daddr = 12'h200;
    w_dwe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_addr = ((i % 5) == 4) ? 12'h100 : 12'h200;
      w_ireq = 1'b1;
      w_dreq = 1'b1;
      tick();
      total++; if (r_maddr !== exp_addr) begin bad++; $display("FAIL starve_order[%0d] got=%h want=%h", i, r_maddr, exp_addr); end
      if (exp_addr == 12'h200) w_ireq = 1'b0; else w_dreq = 1'b0;
      tick();
      tick();
      total++;
      if (exp_addr == 12'h200) begin
        if (r_dack !== 1'b1 || r_ddata !== 32'hDA7A_0200) begin bad++; $display("FAIL starve_dack[%0d] got=%b/%h want=1/da7a0200", i, r_dack, r_ddata); end
      end else begin
        if (r_iack !== 1'b1 || r_idata !== 32'hF00D_0100) begin bad++; $display("FAIL starve_iack[%0d] got=%b/%h want=1/f00d0100", i, r_iack, r_idata); end
      end
      tick();
      total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL starve_dup[%0d] busy got=%b want=0", i, r_busy); end
    end
    w_ireq = 1'b0;
    w_dreq = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    w_ireq = 1'b1;
    w_iaddr = 12'h030;
    tick();
    w_dreq = 1'b1;
    w_dwe = 1'b0;
    w_daddr = 12'h031;
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    total++; if (r_iack !== 1'b0 || r_busy !== 1'b0) begin bad++; $display("FAIL rst_resp got ack/busy=%b/%b want=0/0", r_iack, r_busy); end
    tick();
    total++; if (r_maddr !== 12'h031 || r_busy !== 1'b1) begin bad++; $display("FAIL rst_data_first got=%h/%b want=031/1", r_maddr, r_busy); end
    tick();
    tick();
    total++; if (r_dack !== 1'b1 || r_ddata !== 32'h3131_3131) begin bad++; $display("FAIL rst_dack got=%b/%h want=1/31313131", r_dack, r_ddata); end
    w_dreq = 1'b0;
    tick();
    total++; if (r_maddr !== 12'h030) begin bad++; $display("FAIL rst_fetch_retry got=%h want=030", r_maddr); end
    tick();
    tick();
    total++; if (r_iack !== 1'b1 || r_idata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_iack got=%b/%h want=1/deadbeef", r_iack, r_idata); end
    w_ireq = 1'b0;
    tick();
  endtask

  task automatic test_reset_during_write();
    int base;
    do_reset();
    base = mwe_pulses;
    w_dreq = 1'b1;
    w_dwe = 1'b1;
    w_daddr = 12'h050;
    w_ddin = 32'h0000_55AA;
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    w_dreq = 1'b0;
    w_dwe = 1'b0;
    total++; if (r_mwe !== 1'b0 || r_dack !== 1'b0 || r_busy !== 1'b0) begin bad++; $display("FAIL rstw_abort got mwe/ack/busy=%b/%b/%b want=0/0/0", r_mwe, r_dack, r_busy); end
    tick();
    total++; if (mwe_pulses - base !== 1) begin bad++; $display("FAIL rstw_pulses got=%0d want=1", mwe_pulses - base); end
    w_dreq = 1'b1;
    tick();
    tick();
    tick();
    total++; if (r_dack !== 1'b1 || r_ddata !== 32'h0000_55AA) begin bad++; $display("FAIL rstw_commit got=%b/%h want=1/000055aa", r_dack, r_ddata); end
    w_dreq = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    w_ireq = 1'b1;
    w_iaddr = 12'h040;
    tick();
    w_dreq = 1'b1;
    w_dwe = 1'b0;
    w_daddr = 12'h042;
    tick();
    tick();
    total++; if (r_iack !== 1'b1 || r_idata !== 32'h4040_4040) begin bad++; $display("FAIL b2b_iack1 got=%b/%h want=1/40404040", r_iack, r_idata); end
    w_ireq = 1'b0;
    tick();
    total++; if (r_maddr !== 12'h042 || r_busy !== 1'b1) begin bad++; $display("FAIL b2b_data_grant got=%h/%b want=042/1", r_maddr, r_busy); end
    w_ireq = 1'b1;
    w_iaddr = 12'h041;
    tick();
    tick();
    total++; if (r_dack !== 1'b1 || r_ddata !== 32'h4242_4242) begin bad++; $display("FAIL b2b_dack got=%b/%h want=1/42424242", r_dack, r_ddata); end
    w_dreq = 1'b0;
    tick();
    total++; if (r_maddr !== 12'h041 || r_busy !== 1'b1) begin bad++; $display("FAIL b2b_fetch_grant got=%h/%b want=041/1", r_maddr, r_busy); end
    tick();
    tick();
    total++; if (r_iack !== 1'b1 || r_idata !== 32'h4141_4141) begin bad++; $display("FAIL b2b_iack2 got=%b/%h want=1/41414141", r_iack, r_idata); end
    w_ireq = 1'b0;
    tick();
    total++; if (r_busy !== 1'b0 || r_iack !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy/ack=%b/%b want=0/0", r_busy, r_iack); end
  endtask

`ifdef MEMARB_STATS_EN
  task automatic test_stats();
    int icnt;
    int dcnt;
    icnt = 0;
    dcnt = 0;
    do_reset();
    w_ireq = 1'b1;
    w_dreq = 1'b1;
    w_dwe = 1'b0;
    w_iaddr = 12'h100;
    w_daddr = 12'h200;
    for (int i = 0; i < 12; i++) begin
      if (r_iack !== 1'b1) icnt++;
      if (r_dack !== 1'b1) dcnt++;
      tick();
    end
    total++; if (r_iwait !== 32'(icnt)) begin bad++; $display("FAIL stats_iwait got=%0d want=%0d", r_iwait, icnt); end
    total++; if (r_dwait !== 32'(dcnt)) begin bad++; $display("FAIL stats_dwait got=%0d want=%0d", r_dwait, dcnt); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_starvation();
    test_reset_in_resp();
    test_reset_during_write();
    test_back_to_back();
`ifdef MEMARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
